// File: rtl/alu_control_md.sv
// ALU control decoder with an iterative RV M-extension multiply/divide engine.
// Base-ISA decode is combinational; mul/div runs one radix-2 step per cycle under a stall handshake.
module alu_control_md #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      ALU_OpIn,
  input  logic [6:0]      func7,
  input  logic [2:0]      func3,
  input  logic            valid_in,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [3:0]      ALU_ControlOut,
  output logic            md_sel,
  output logic            stall,
  output logic [XLEN-1:0] md_result,
  output logic            md_done
);

  localparam int unsigned CW = $clog2(XLEN + 1);
  localparam int unsigned PW = 2 * XLEN;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d;
  logic            bzero_q, bzero_d;
  logic [XLEN-1:0] md_result_q, md_result_d;
  logic            md_done_q, md_done_d;

  // Base-ISA / M-extension decode, independent of engine state.
  always_comb begin
    ALU_ControlOut = 4'b1111;
    md_sel         = 1'b0;
    case (ALU_OpIn)
      2'b00: ALU_ControlOut = 4'b0010;
      2'b01: ALU_ControlOut = 4'b0110;
      2'b10: begin
        case (func7)
          7'b0000000: begin
            case (func3)
              3'b000:  ALU_ControlOut = 4'b0010;
              3'b001:  ALU_ControlOut = 4'b0100;
              3'b010:  ALU_ControlOut = 4'b1000;
              3'b011:  ALU_ControlOut = 4'b1001;
              3'b100:  ALU_ControlOut = 4'b0011;
              3'b101:  ALU_ControlOut = 4'b0101;
              3'b110:  ALU_ControlOut = 4'b0001;
              default: ALU_ControlOut = 4'b0000;
            endcase
          end
          7'b0100000: begin
            if (func3 == 3'b000) begin
              ALU_ControlOut = 4'b0110;
            end else if (func3 == 3'b101) begin
              ALU_ControlOut = 4'b0111;
            end
          end
          7'b0000001: md_sel = 1'b1;
          default:    ALU_ControlOut = 4'b1111;
        endcase
      end
      default: ALU_ControlOut = 4'b1111;
    endcase
  end

  // Operand magnitudes; signedness follows the func3 of the op being accepted.
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;

  always_comb begin
    a_signed = !(func3 inside {3'b011, 3'b101, 3'b111});
    b_signed = func3 inside {3'b000, 3'b001, 3'b100, 3'b110};
    a_neg    = a_signed & rs1[XLEN-1];
    b_neg    = b_signed & rs2[XLEN-1];
    a_mag    = a_neg ? -rs1 : rs1;
    b_mag    = b_neg ? -rs2 : rs2;
  end

  // One radix-2 step: shift-add multiply or restoring divide on {hi, lo}.
  logic [XLEN:0]   mul_sum, div_shift;
  logic            div_ge;
  logic [XLEN-1:0] step_hi, step_lo;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_ge    = div_shift >= {1'b0, b_q};
    if (op_q[2]) begin
      step_hi = div_ge ? XLEN'(div_shift - {1'b0, b_q}) : div_shift[XLEN-1:0];
      step_lo = {lo_q[XLEN-2:0], div_ge};
    end else begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  // Sign fix-up and result selection from the final step's values.
  logic [PW-1:0]   prod, prod_s;
  logic [XLEN-1:0] quo, rem, final_res;

  always_comb begin
    prod   = {step_hi, step_lo};
    prod_s = neg_q ? -prod : prod;
    quo    = bzero_q ? '1 : (neg_q ? -step_lo : step_lo);
    rem    = neg_q ? -step_hi : step_hi;
    case (op_q)
      3'b000:                    final_res = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011:    final_res = prod_s[PW-1:XLEN];
      3'b100, 3'b101:            final_res = quo;
      default:                   final_res = rem;
    endcase
  end

  // Engine FSM next-state and stall.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    op_d        = op_q;
    neg_d       = neg_q;
    bzero_d     = bzero_q;
    md_result_d = md_result_q;
    md_done_d   = 1'b0;
    stall       = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_in && md_sel) begin
          stall   = 1'b1;
          state_d = BUSY;
          cnt_d   = CW'(XLEN);
          a_d     = a_mag;
          b_d     = b_mag;
          hi_d    = '0;
          lo_d    = func3[2] ? a_mag : b_mag;
          op_d    = func3;
          neg_d   = (func3[2] & func3[1]) ? a_neg : (a_neg ^ b_neg);
          bzero_d = (rs2 == '0);
        end
      end
      BUSY: begin
        stall = 1'b1;
        cnt_d = cnt_q - CW'(1);
        hi_d  = step_hi;
        lo_d  = step_lo;
        if (cnt_q == CW'(1)) begin
          state_d     = DONE;
          md_done_d   = 1'b1;
          md_result_d = final_res;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (reset) begin
      stall = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      op_q        <= '0;
      neg_q       <= 1'b0;
      bzero_q     <= 1'b0;
      md_result_q <= '0;
      md_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      op_q        <= op_d;
      neg_q       <= neg_d;
      bzero_q     <= bzero_d;
      md_result_q <= md_result_d;
      md_done_q   <= md_done_d;
    end
  end

  assign md_result = md_result_q;
  assign md_done   = md_done_q;

endmodule

// File: tb/tb_alu_control_md.sv
// Bench for alu_control_md: XLEN=32 and XLEN=8 instances, directed and random
// mul/div ops checked against a wide-integer arithmetic model.
module tb_alu_control_md;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic [1:0]  op32;
  logic [6:0]  f7_32;
  logic [2:0]  f3_32;
  logic        v32;
  logic [31:0] a32, b32, res32;
  logic [3:0]  ctl32;
  logic        sel32, st32, dn32;

  logic [1:0]  op8;
  logic [6:0]  f7_8;
  logic [2:0]  f3_8;
  logic        v8;
  logic [7:0]  a8, b8, res8;
  logic [3:0]  ctl8;
  logic        sel8, st8, dn8;

  int errors = 0;
  int checks = 0;

  alu_control_md #(.XLEN(32)) dut32 (
    .clk(clk), .reset(reset), .ALU_OpIn(op32), .func7(f7_32), .func3(f3_32),
    .valid_in(v32), .rs1(a32), .rs2(b32), .ALU_ControlOut(ctl32), .md_sel(sel32),
    .stall(st32), .md_result(res32), .md_done(dn32)
  );

  alu_control_md #(.XLEN(8)) dut8 (
    .clk(clk), .reset(reset), .ALU_OpIn(op8), .func7(f7_8), .func3(f3_8),
    .valid_in(v8), .rs1(a8), .rs2(b8), .ALU_ControlOut(ctl8), .md_sel(sel8),
    .stall(st8), .md_result(res8), .md_done(dn8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: RISC-V M semantics using wide signed integers.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b, input int w);
    logic signed [127:0] mask, ua, ub, sa, sb, r;
    mask = (128'sd1 <<< w) - 128'sd1;
    ua   = $signed({96'd0, a}) & mask;
    ub   = $signed({96'd0, b}) & mask;
    sa   = ua[w-1] ? ua - (mask + 128'sd1) : ua;
    sb   = ub[w-1] ? ub - (mask + 128'sd1) : ub;
    case (f3)
      3'd0:    r = sa * sb;
      3'd1:    r = (sa * sb) >>> w;
      3'd2:    r = (sa * ub) >>> w;
      3'd3:    r = (ua * ub) >>> w;
      3'd4:    r = (ub == 0) ? mask : sa / sb;
      3'd5:    r = (ub == 0) ? mask : ua / ub;
      3'd6:    r = (ub == 0) ? ua : sa % sb;
      default: r = (ub == 0) ? ua : ua % ub;
    endcase
    return 32'(r & mask);
  endfunction

  task automatic drive(input bit s8, input logic v, input logic [1:0] op, input logic [6:0] f7,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (s8) begin
      v8 = v; op8 = op; f7_8 = f7; f3_8 = f3; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      v32 = v; op32 = op; f7_32 = f7; f3_32 = f3; a32 = a; b32 = b;
    end
  endtask

  function automatic logic get_stall(input bit s8);
    return s8 ? st8 : st32;
  endfunction
  function automatic logic get_done(input bit s8);
    return s8 ? dn8 : dn32;
  endfunction
  function automatic logic get_sel(input bit s8);
    return s8 ? sel8 : sel32;
  endfunction
  function automatic logic [3:0] get_ctl(input bit s8);
    return s8 ? ctl8 : ctl32;
  endfunction
  function automatic logic [31:0] get_res(input bit s8);
    return s8 ? 32'(res8) : res32;
  endfunction

  task automatic dec(input bit s8, input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                     input logic [3:0] ec, input logic es, input string tag);
    @(negedge clk);
    drive(s8, !es, op, f7, f3, $urandom, $urandom);
    #1;
    check({tag, " ctl"}, 32'(get_ctl(s8)), 32'(ec));
    check({tag, " sel"}, 32'(get_sel(s8)), 32'(es));
    if (!es) check({tag, " stall"}, 32'(get_stall(s8)), 32'd0);
  endtask

  // Issue one M op and follow it to completion; hold keeps the request asserted through DONE.
  task automatic do_op(input bit s8, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expv, input bit hold, input string tag);
    int w, stall_n, done_n, done_at;
    w = s8 ? 8 : 32;
    stall_n = 0;
    done_n  = 0;
    done_at = -1;
    @(negedge clk);
    drive(s8, 1'b1, 2'b10, 7'b0000001, f3, a, b);
    #1;
    check({tag, " sel"}, 32'(get_sel(s8)), 32'd1);
    check({tag, " done_at_accept"}, 32'(get_done(s8)), 32'd0);
    for (int n = 0; n <= w + 1; n++) begin
      if (n > 0) begin
        @(negedge clk);
        if (!hold && n < w)
          drive(s8, 1'($urandom), 2'b10, ($urandom % 2 == 0) ? 7'b0000001 : 7'($urandom),
                3'($urandom), $urandom, $urandom);
        if (!hold && n == w) drive(s8, 1'b0, 2'b00, 7'd0, 3'd0, 32'd0, 32'd0);
        #1;
      end
      if (get_stall(s8)) stall_n++;
      if (get_done(s8)) begin
        done_n++;
        if (done_at < 0) begin
          done_at = n;
          check({tag, " result"}, get_res(s8), expv);
        end
      end
    end
    check({tag, " latency"}, 32'(done_at), 32'(w + 1));
    check({tag, " stall_cycles"}, 32'(stall_n), 32'(w + 1));
    check({tag, " pulses"}, 32'(done_n), 32'd1);
    if (!hold) begin
      @(negedge clk);
      #1;
      check({tag, " done_after"}, 32'(get_done(s8)), 32'd0);
      check({tag, " result_hold"}, get_res(s8), expv);
    end
  endtask

  task automatic rand_op(input bit s8, input string tag);
    logic [2:0]  f3;
    logic [31:0] a, b;
    f3 = 3'($urandom_range(0, 7));
    a  = $urandom;
    b  = $urandom;
    case ($urandom_range(0, 3))
      0: ;
      1: begin
        a = 32'($signed($urandom_range(0, 50)) - 25);
        b = 32'($signed($urandom_range(0, 20)) - 10);
      end
      2: b = 32'd0;
      default: begin
        a = s8 ? 32'h80 : 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
    endcase
    do_op(s8, f3, a, b, model(f3, a, b, s8 ? 8 : 32), 1'b0, tag);
  endtask

  initial begin
    int pulses;
    reset = 1'b1;
    drive(1'b0, 1'b1, 2'b10, 7'b0000001, 3'd0, 32'd7, 32'd3);
    drive(1'b1, 1'b1, 2'b10, 7'b0000001, 3'd0, 32'd7, 32'd3);
    repeat (2) @(negedge clk);
    #1;
    check("rst stall32", 32'(st32), 32'd0);
    check("rst done32", 32'(dn32), 32'd0);
    check("rst res32", res32, 32'd0);
    check("rst stall8", 32'(st8), 32'd0);
    check("rst res8", 32'(res8), 32'd0);
    drive(1'b0, 1'b0, 2'b00, 7'd0, 3'd0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 2'b00, 7'd0, 3'd0, 32'd0, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    dec(1'b0, 2'b00, 7'($urandom), 3'($urandom), 4'b0010, 1'b0, "dec ld");
    dec(1'b0, 2'b01, 7'($urandom), 3'($urandom), 4'b0110, 1'b0, "dec br");
    dec(1'b0, 2'b11, 7'b0000001, 3'd0, 4'b1111, 1'b0, "dec op11");
    dec(1'b0, 2'b10, 7'b0000000, 3'b000, 4'b0010, 1'b0, "dec add");
    dec(1'b0, 2'b10, 7'b0000000, 3'b001, 4'b0100, 1'b0, "dec sll");
    dec(1'b0, 2'b10, 7'b0000000, 3'b010, 4'b1000, 1'b0, "dec slt");
    dec(1'b0, 2'b10, 7'b0000000, 3'b011, 4'b1001, 1'b0, "dec sltu");
    dec(1'b0, 2'b10, 7'b0000000, 3'b100, 4'b0011, 1'b0, "dec xor");
    dec(1'b0, 2'b10, 7'b0000000, 3'b101, 4'b0101, 1'b0, "dec srl");
    dec(1'b0, 2'b10, 7'b0000000, 3'b110, 4'b0001, 1'b0, "dec or");
    dec(1'b0, 2'b10, 7'b0000000, 3'b111, 4'b0000, 1'b0, "dec and");
    dec(1'b0, 2'b10, 7'b0100000, 3'b000, 4'b0110, 1'b0, "dec sub");
    dec(1'b0, 2'b10, 7'b0100000, 3'b101, 4'b0111, 1'b0, "dec sra");
    dec(1'b0, 2'b10, 7'b0100000, 3'b010, 4'b1111, 1'b0, "dec alt bad");
    dec(1'b0, 2'b10, 7'b1111111, 3'b000, 4'b1111, 1'b0, "dec f7 bad");
    dec(1'b0, 2'b10, 7'b0000001, 3'b100, 4'b1111, 1'b1, "dec div");
    dec(1'b1, 2'b10, 7'b0000000, 3'b111, 4'b0000, 1'b0, "dec8 and");
    dec(1'b1, 2'b10, 7'b0000001, 3'b011, 4'b1111, 1'b1, "dec8 mulhu");
    drive(1'b0, 1'b0, 2'b00, 7'd0, 3'd0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 2'b00, 7'd0, 3'd0, 32'd0, 32'd0);

    do_op(1'b0, 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, "mul 7*-3");
    do_op(1'b0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, "mulhu max");
    do_op(1'b0, 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1'b0, "mulhsu -1*2");
    do_op(1'b0, 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, "div -7/2");
    do_op(1'b0, 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, "rem -7/2");
    do_op(1'b0, 3'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 1'b0, "divu by0");
    do_op(1'b0, 3'd6, 32'd5, 32'd0, 32'd5, 1'b0, "rem 5/0");
    do_op(1'b0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, "div ovf");
    do_op(1'b0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, "rem ovf");

    do_op(1'b0, 3'd0, 32'd5, 32'd6, 32'd30, 1'b1, "b2b mul");
    do_op(1'b0, 3'd5, 32'd100, 32'd7, 32'd14, 1'b0, "b2b divu");

    // Reset mid-operation.
    @(negedge clk);
    drive(1'b0, 1'b1, 2'b10, 7'b0000001, 3'd0, 32'd9, 32'd9);
    #1;
    check("rstbusy accept stall", 32'(st32), 32'd1);
    repeat (10) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 2'b00, 7'd0, 3'd0, 32'd0, 32'd0);
    end
    #1;
    check("rstbusy busy stall", 32'(st32), 32'd1);
    reset = 1'b1;
    #1;
    check("rstbusy stall in rst", 32'(st32), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rstbusy stall", 32'(st32), 32'd0);
    check("rstbusy done", 32'(dn32), 32'd0);
    check("rstbusy res", res32, 32'd0);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (dn32) pulses++;
    end
    check("rstbusy no pulse", 32'(pulses), 32'd0);
    do_op(1'b0, 3'd0, 32'd12, 32'd11, 32'd132, 1'b0, "mul after rst");

    do_op(1'b1, 3'd1, 32'h80, 32'h80, 32'h40, 1'b0, "x8 mulh");
    do_op(1'b1, 3'd4, 32'd100, 32'd7, 32'd14, 1'b0, "x8 div");

    for (int i = 0; i < 20; i++) rand_op(1'b0, $sformatf("rnd32 #%0d", i));
    for (int i = 0; i < 20; i++) rand_op(1'b1, $sformatf("rnd8 #%0d", i));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_control_md.md
# alu_control_md

Parametrised successor of the single-cycle ALU control decoder. It keeps the combinational base-ISA decode (ALU_OpIn/func7/func3 to a 4-bit ALU_ControlOut) and adds an iterative RV M-extension multiply/divide engine with a stall handshake. It sits in the execute stage beside the ALU; the pipeline freezes while `stall` is high and takes `md_result` on `md_done`.

## Interface
- XLEN, 32, operand/result width; legal values >= 4
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- ALU_OpIn  input  2  main-control ALU op class (00 load/store, 01 branch, 10 R-type)
- func7  input  7  instruction bits [31:25]
- func3  input  3  instruction bits [14:12]
- valid_in  input  1  decoded instruction in execute is valid this cycle
- rs1, rs2  input  XLEN  operand values
- ALU_ControlOut  output  4  combinational ALU operation code
- md_sel  output  1  combinational; current decode is an M-extension op
- stall  output  1  combinational; hold pipeline
- md_result  output  XLEN  registered mul/div result
- md_done  output  1  registered one-cycle completion pulse

## Operation
- Base decode (combinational, md_sel=0): ALU_OpIn 00 -> 0010 (add); 01 -> 0110 (sub); 11 -> 1111.
- ALU_OpIn 10, func7 0000000: func3 000 add 0010, 001 sll 0100, 010 slt 1000, 011 sltu 1001, 100 xor 0011, 101 srl 0101, 110 or 0001, 111 and 0000.
- ALU_OpIn 10, func7 0100000: func3 000 sub 0110, 101 sra 0111; other func3 -> 1111.
- ALU_OpIn 10, func7 0000001: md_sel=1, ALU_ControlOut=1111. func3 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Any other func7 with ALU_OpIn 10 -> 1111, md_sel=0.
- States: IDLE, BUSY, DONE.
- IDLE: if valid_in & md_sel -> latch rs1, rs2, func3; load iteration counter with XLEN; go BUSY.
- BUSY: one radix-2 step per cycle (shift-add multiply into 2*XLEN product; restoring divide on magnitudes). Counter decrements; at zero go DONE.
- DONE: md_done=1 for exactly one cycle, md_result valid; return IDLE. No new op is accepted in DONE even if valid_in & md_sel is still high.
- Signedness: MUL/MULH/DIV/REM signed both operands; MULHSU rs1 signed, rs2 unsigned; MULHU/DIVU/REMU unsigned. Magnitudes are iterated; product/quotient is negated when operand signs differ; remainder takes the dividend's sign.
- Result: MUL low XLEN of product; MULH* high XLEN; DIV*/REM* quotient/remainder.
- Divide by zero: quotient all ones, remainder = dividend (DIV, DIVU, REM, REMU alike).
- Signed overflow (DIV/REM of -2^(XLEN-1) by -1): quotient -2^(XLEN-1), remainder 0.
- Special cases use the same fixed latency as normal operations.
- md_result holds its value until the next DONE.

## Timing
- Reset values: state IDLE, md_done 0, md_result 0. stall is 0 while reset is high.
- stall = (IDLE & valid_in & md_sel) | BUSY. It is 0 in DONE and 0 for base-ISA ops.
- Accept in cycle T: stall high T..T+XLEN. md_done and md_result are valid at T+XLEN+1 with stall low. Total latency is XLEN+1 cycles.
- Back-to-back: the next M op presented at T+XLEN+2 (in IDLE) is accepted that cycle.
- valid_in low or md_sel low in BUSY is ignored; latched operands are used.
- Reset in BUSY or DONE: next cycle IDLE, md_done 0, md_result 0, no pulse emitted.
- ALU_ControlOut and md_sel have zero latency and are independent of state.

## Test plan
- Base decode sweep: 00/x/x -> 0010; 01 -> 0110; 10/0000000/000 -> 0010; 10/0100000/000 -> 0110; 10/0000000/111 -> 0000; 10/0000000/110 -> 0001; 10/0100000/101 -> 0111; 10/1111111/000 -> 1111.
- XLEN=32, MUL rs1=7, rs2=-3: stall high 33 cycles, md_done at T+33, md_result=0xFFFFFFEB. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU -1,2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF. DIVU 0x80000000/0 -> 0xFFFFFFFF. REM 5/0 -> 5. DIV 0x80000000/-1 -> 0x80000000. REM 0x80000000/-1 -> 0.
- Back-to-back MUL then DIVU with valid_in held high: exactly one md_done per op. The second op starts the cycle after DONE. No double acceptance in DONE.
- Assert reset at BUSY cycle 10: next cycle state IDLE, stall 0, md_done stays 0, md_result 0. A fresh MUL after reset completes normally.
- XLEN=8 instance: MULH -128*-128 -> 0x40; DIV 100/7 -> 14, latency 9 cycles.
